lbm_moment_accum: RTL and testbench

// - Sequential D2Q9 moment stage that sits directly downstream of the lattice-velocity constant registers (cx/cy).
// - Consumes 9 populations f_k plus the cx/cy vectors and produces density Rho = sum f_k.
// - Also produces momenta Mx = sum f_k*cx_k and My = sum f_k*cy_k, one direction per clock.
// - Feeds the equilibrium stage. All values are signed Q8.56 in 64-bit words.

---
 rtl/lbm_pkg.sv | 28 ++
 rtl/lbm_c_mac.sv | 27 ++
 rtl/lbm_moment_accum.sv | 147 ++++++++++++++
 tb/tb_lbm_moment_accum.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbm_pkg.sv
// Shared definitions for the lattice-Boltzmann moment stage.
// Holds the word/direction geometry, the signed Q8.56 value type,
// the +1.0 / -1.0 constants, the FSM state type and a helper that
// slices direction k out of a packed D2Q9 vector.
package lbm_pkg;

    localparam int unsigned LBM_WORD  = 64;
    localparam int unsigned LBM_NDIR  = 9;
    localparam int unsigned LBM_FRAC  = 56;
    localparam int unsigned LBM_WIDTH = LBM_WORD * LBM_NDIR;

    typedef logic signed [LBM_WORD-1:0] lbm_fix_t;

    localparam lbm_fix_t LBM_ONE  = lbm_fix_t'(64'sd1 <<< LBM_FRAC);
    localparam lbm_fix_t LBM_MONE = -LBM_ONE;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } lbm_state_e;

    // Direction k is stored at bits [(NDIR-1-k)*WORD +: WORD], so k=0 is the MSB word.
    function automatic lbm_fix_t lbm_dir(input logic [LBM_WIDTH-1:0] vec,
                                         input logic [3:0]           k);
        return vec[(LBM_NDIR - 1 - {28'd0, k}) * LBM_WORD +: LBM_WORD];
    endfunction

endpackage

// File: rtl/lbm_c_mac.sv
// Multiplier-free lattice-velocity MAC step.
// Ports:
//   acc_i  running momentum sum
//   f_i    population for the current direction
//   c_i    velocity component (0, +1.0 or -1.0; any nonzero magnitude acts as +/-1.0)
//   sum_o  acc_i, acc_i + f_i or acc_i - f_i depending on c_i
module lbm_c_mac
    import lbm_pkg::*;
(
    input  lbm_fix_t acc_i,
    input  lbm_fix_t f_i,
    input  lbm_fix_t c_i,
    output lbm_fix_t sum_o
);

    always_comb begin
        sum_o = acc_i;
        if (c_i == '0) begin
            sum_o = acc_i;
        end else if (c_i[LBM_WORD-1]) begin
            sum_o = acc_i - f_i;
        end else begin
            sum_o = acc_i + f_i;
        end
    end

endmodule

// File: rtl/lbm_moment_accum.sv
// Sequential D2Q9 moment stage: Rho = sum f_k, Mx = sum f_k*cx_k,
// My = sum f_k*cy_k, one direction per clock, signed Q8.56, wrapping.
// Ports:
//   Clk            system clock, all state on posedge
//   Reset          synchronous active-low reset
//   Start          request, sampled only while idle
//   F_In           9 packed populations (k=0 in the top word)
//   Cx_In / Cy_In  packed lattice velocities, same packing
//   Rho / Mx / My  results, held until the next completion or reset
//   Busy           high while accumulating
//   Done           one-cycle pulse when results become valid
module lbm_moment_accum
    import lbm_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [LBM_WIDTH-1:0] F_In,
    input  logic [LBM_WIDTH-1:0] Cx_In,
    input  logic [LBM_WIDTH-1:0] Cy_In,
    output logic [LBM_WORD-1:0]  Rho,
    output logic [LBM_WORD-1:0]  Mx,
    output logic [LBM_WORD-1:0]  My,
    output logic                 Busy,
    output logic                 Done
);

    lbm_state_e           state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [LBM_WIDTH-1:0] f_q, f_d;
    logic [LBM_WIDTH-1:0] cx_q, cx_d;
    logic [LBM_WIDTH-1:0] cy_q, cy_d;
    lbm_fix_t             acc_rho_q, acc_rho_d;
    lbm_fix_t             acc_mx_q, acc_mx_d;
    lbm_fix_t             acc_my_q, acc_my_d;
    lbm_fix_t             rho_q, rho_d;
    lbm_fix_t             mx_q, mx_d;
    lbm_fix_t             my_q, my_d;
    logic                 done_q, done_d;

    lbm_fix_t f_cur;
    lbm_fix_t rho_nxt, mx_nxt, my_nxt;
    logic     last_dir;

    assign f_cur    = lbm_dir(f_q, idx_q);
    assign rho_nxt  = acc_rho_q + f_cur;
    assign last_dir = (idx_q == 4'(LBM_NDIR - 1));

    lbm_c_mac u_mac_x (
        .acc_i (acc_mx_q),
        .f_i   (f_cur),
        .c_i   (lbm_dir(cx_q, idx_q)),
        .sum_o (mx_nxt)
    );

    lbm_c_mac u_mac_y (
        .acc_i (acc_my_q),
        .f_i   (f_cur),
        .c_i   (lbm_dir(cy_q, idx_q)),
        .sum_o (my_nxt)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        f_d       = f_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        acc_rho_d = acc_rho_q;
        acc_mx_d  = acc_mx_q;
        acc_my_d  = acc_my_q;
        rho_d     = rho_q;
        mx_d      = mx_q;
        my_d      = my_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    f_d       = F_In;
                    cx_d      = Cx_In;
                    cy_d      = Cy_In;
                    acc_rho_d = '0;
                    acc_mx_d  = '0;
                    acc_my_d  = '0;
                    idx_d     = '0;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_rho_d = rho_nxt;
                acc_mx_d  = mx_nxt;
                acc_my_d  = my_nxt;
                idx_d     = idx_q + 4'd1;
                if (last_dir) begin
                    // Publish the sums that already include the final direction.
                    rho_d   = rho_nxt;
                    mx_d    = mx_nxt;
                    my_d    = my_nxt;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            f_q       <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            acc_rho_q <= '0;
            acc_mx_q  <= '0;
            acc_my_q  <= '0;
            rho_q     <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            f_q       <= f_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            acc_rho_q <= acc_rho_d;
            acc_mx_q  <= acc_mx_d;
            acc_my_q  <= acc_my_d;
            rho_q     <= rho_d;
            mx_q      <= mx_d;
            my_q      <= my_d;
            done_q    <= done_d;
        end
    end

    assign Rho  = rho_q;
    assign Mx   = mx_q;
    assign My   = my_q;
    assign Done = done_q;
    assign Busy = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_lbm_moment_accum.sv
// Self-checking bench for lbm_moment_accum: directed D2Q9 scenarios plus
// randomized populations/velocities against a dot-product reference model.
module tb_lbm_moment_accum;
    import lbm_pkg::*;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [575:0] F_In, Cx_In, Cy_In;
    logic [63:0]  Rho, Mx, My;
    logic         Busy, Done;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] fv  [9];
    logic [63:0] cxv [9];
    logic [63:0] cyv [9];

    int sx [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
    int sy [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

    always #5 Clk = ~Clk;

    lbm_moment_accum dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .F_In  (F_In),
        .Cx_In (Cx_In),
        .Cy_In (Cy_In),
        .Rho   (Rho),
        .Mx    (Mx),
        .My    (My),
        .Busy  (Busy),
        .Done  (Done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: sum over k of coef(c_k) * f_k, coef in {-1,0,+1} from the sign of c_k.
    function automatic logic [63:0] model(input int sel);
        longint s;
        longint coef;
        logic [63:0] c;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            c = (sel == 1) ? cxv[k] : cyv[k];
            if (sel == 0)                  coef = 1;
            else if (c == 64'd0)           coef = 0;
            else if ($signed(c) < 64'sd0)  coef = -1;
            else                           coef = 1;
            s = s + coef * longint'(fv[k]);
        end
        return 64'(s);
    endfunction

    function automatic logic [63:0] vel(input int v);
        if (v == 0) return 64'd0;
        return (v > 0) ? LBM_ONE : LBM_MONE;
    endfunction

    function automatic logic [63:0] rand_c();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return LBM_ONE;
            2:       return LBM_MONE;
            3:       return {1'b0, r[62:1], 1'b1};
            default: return {1'b1, r[62:0]};
        endcase
    endfunction

    task automatic set_std(input logic [63:0] fill);
        for (int k = 0; k < 9; k++) begin
            fv[k]  = fill;
            cxv[k] = vel(sx[k]);
            cyv[k] = vel(sy[k]);
        end
    endtask

    task automatic set_rand();
        for (int k = 0; k < 9; k++) begin
            fv[k]  = {$urandom, $urandom};
            cxv[k] = rand_c();
            cyv[k] = rand_c();
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 9; k++) begin
            F_In [(8-k)*64 +: 64] = fv[k];
            Cx_In[(8-k)*64 +: 64] = cxv[k];
            Cy_In[(8-k)*64 +: 64] = cyv[k];
        end
    endtask

    // Called #1 after an edge; request is accepted at the next edge.
    task automatic start_op(input string tag);
        drive();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check({tag, ":busy_on_accept"}, 64'(Busy), 64'd1);
    endtask

    task automatic finish_op(input string tag, input int poke, input bit chain);
        logic [63:0] er, ex, ey;
        int n;
        bit seen;
        er = model(0);
        ex = model(1);
        ey = model(2);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            if (n == poke) begin
                Start = 1'b1;
                F_In  = ~F_In;
                Cx_In = ~Cx_In;
            end
            @(posedge Clk); #1;
            n++;
            if (n == poke + 1) Start = 1'b0;
            if (Done) seen = 1'b1;
            else      check({tag, ":busy"}, 64'(Busy), 64'd1);
        end
        check({tag, ":latency"}, 64'(n), 64'd9);
        check({tag, ":busy_at_done"}, 64'(Busy), 64'd0);
        check({tag, ":rho"}, Rho, er);
        check({tag, ":mx"}, Mx, ex);
        check({tag, ":my"}, My, ey);
        if (chain) begin
            set_rand();
            drive();
            Start = 1'b1;
            @(posedge Clk); #1;
            Start = 1'b0;
            check({tag, ":chain_done_clear"}, 64'(Done), 64'd0);
            check({tag, ":chain_accepted"}, 64'(Busy), 64'd1);
        end else begin
            @(posedge Clk); #1;
            check({tag, ":done_pulse"}, 64'(Done), 64'd0);
            check({tag, ":rho_hold"}, Rho, er);
        end
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        F_In  = '0;
        Cx_In = '0;
        Cy_In = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset:busy", 64'(Busy), 64'd0);
        check("reset:done", 64'(Done), 64'd0);
        check("reset:rho", Rho, 64'd0);
        check("reset:mx", Mx, 64'd0);
        check("reset:my", My, 64'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // All populations 1.0: opposite velocities cancel.
        set_std(LBM_ONE);
        start_op("ones");
        finish_op("ones", -1, 1'b0);
        check("ones:rho_lit", Rho, 64'h0900000000000000);
        check("ones:mx_lit", Mx, 64'd0);
        check("ones:my_lit", My, 64'd0);

        // Only f_1 = 2.0 (east).
        set_std(64'd0);
        fv[1] = 64'h0200000000000000;
        start_op("f1");
        finish_op("f1", -1, 1'b0);
        check("f1:rho_lit", Rho, 64'h0200000000000000);
        check("f1:mx_lit", Mx, 64'h0200000000000000);
        check("f1:my_lit", My, 64'd0);

        // Only f_7 = 1.0 (south-west).
        set_std(64'd0);
        fv[7] = LBM_ONE;
        start_op("f7");
        finish_op("f7", -1, 1'b0);
        check("f7:rho_lit", Rho, LBM_ONE);
        check("f7:mx_lit", Mx, 64'hFF00000000000000);
        check("f7:my_lit", My, 64'hFF00000000000000);

        // Overflow wraps: 9 * 0x7F = 0x477 -> 0x77 in the integer byte.
        set_std(64'h7F00000000000000);
        start_op("wrap");
        finish_op("wrap", -1, 1'b0);
        check("wrap:rho_lit", Rho, 64'h7700000000000000);

        // Start re-asserted mid-operation (and inputs changed): ignored.
        set_rand();
        start_op("restart");
        finish_op("restart", 3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk); #1;
            check("restart:no_second_done", 64'(Done), 64'd0);
        end

        // Reset in the middle of an operation discards it.
        set_rand();
        start_op("midreset");
        repeat (4) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("midreset:busy", 64'(Busy), 64'd0);
        check("midreset:done", 64'(Done), 64'd0);
        check("midreset:rho", Rho, 64'd0);
        check("midreset:mx", Mx, 64'd0);
        check("midreset:my", My, 64'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        set_rand();
        start_op("after_reset");
        finish_op("after_reset", -1, 1'b0);

        // Random operations, with back-to-back Start during the Done cycle.
        for (int i = 0; i < 6; i++) begin
            set_rand();
            start_op("rand_a");
            finish_op("rand_a", -1, 1'b1);
            finish_op("rand_b", -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
